// File: rtl/single_ram_ext_module.sv
// single_ram_ext_module: single-port RAM with byte write enables,
// 1/2-cycle read latency, read-during-write modes and post-reset clear.
module single_ram_ext_module #(
  parameter int P_DATA_WIDTH   = 32,
  parameter int P_BYTE_WIDTH   = 8,
  parameter int P_ADDR_DEPTH   = 128,
  parameter int P_READ_LATENCY = 1,
  parameter int P_RDW_MODE     = 0,
  localparam int LP_NB = P_DATA_WIDTH / P_BYTE_WIDTH,
  localparam int LP_AW = (P_ADDR_DEPTH > 1) ? $clog2(P_ADDR_DEPTH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_ena,
  input  logic [LP_NB-1:0]        i_wea,
  input  logic [P_DATA_WIDTH-1:0] i_wdata,
  input  logic [LP_AW-1:0]        i_addr,
  output logic [P_DATA_WIDTH-1:0] o_rdata,
  output logic                    o_rvalid,
  output logic                    o_ready
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [LP_AW:0] LP_DEPTH =
    (LP_AW+1)'(P_ADDR_DEPTH);
  localparam logic [LP_AW-1:0] LP_LAST =
    LP_AW'(P_ADDR_DEPTH - 1);

  logic [P_DATA_WIDTH-1:0] mem_q [P_ADDR_DEPTH];

  logic [0:0]              state_q, state_d;
  logic [LP_AW-1:0]        cnt_q, cnt_d;
  logic                    acc, in_range, is_wr;
  logic [P_DATA_WIDTH-1:0] old_word, merged, rd_val;
  logic                    rd_fire;
  logic                    mem_we;
  logic [LP_AW-1:0]        mem_wa;
  logic [P_DATA_WIDTH-1:0] mem_wd;
  logic                    v1_q;
  logic [P_DATA_WIDTH-1:0] d1_q;

  assign o_ready  = (state_q == ST_RUN);
  assign acc      = i_ena & o_ready;
  assign in_range = ({1'b0, i_addr} < LP_DEPTH);
  assign is_wr    = |i_wea;
  assign old_word = in_range ? mem_q[i_addr] : '0;

  // Byte-lane merge of write data over the currently stored word
  always_comb begin
    merged = old_word;
    for (int k = 0; k < LP_NB; k++) begin
      if (i_wea[k]) begin
        merged[k*P_BYTE_WIDTH +: P_BYTE_WIDTH] =
          i_wdata[k*P_BYTE_WIDTH +: P_BYTE_WIDTH];
      end
    end
  end

  // Select returned word and whether a read response is produced
  always_comb begin
    rd_fire = acc;
    rd_val  = old_word;
    if (is_wr) begin
      case (P_RDW_MODE)
        1:       rd_val  = in_range ? merged : '0;
        2:       rd_fire = 1'b0;
        default: rd_val  = old_word;
      endcase
    end
  end

  // Clear-sweep sequencing: INIT walks every word once, then RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LP_LAST) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end
  end

  // FSM and clear counter registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array port is shared by the clear sweep and user writes
  assign mem_we = i_rst & ((state_q == ST_INIT) |
                           (acc & is_wr & in_range));
  assign mem_wa = (state_q == ST_INIT) ? cnt_q : i_addr;
  assign mem_wd = (state_q == ST_INIT) ? '0 : merged;

  // Storage array, deliberately without reset
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  // First read stage; data holds when no response is issued
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= rd_fire;
      if (rd_fire) begin
        d1_q <= rd_val;
      end
    end
  end

  if (P_READ_LATENCY == 2) begin : g_lat2
    logic                    v2_q;
    logic [P_DATA_WIDTH-1:0] d2_q;

    // Extra output register; reset drops a response still in flight
    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          d2_q <= d1_q;
        end
      end
    end

    assign o_rvalid = v2_q;
    assign o_rdata  = d2_q;
  end else begin : g_lat1
    assign o_rvalid = v1_q;
    assign o_rdata  = d1_q;
  end

endmodule

// File: tb/tb_single_ram_ext_module.sv
// tb_single_ram_ext_module: three RAM variants on shared stimulus,
// each compared every cycle against a behavioural model.
module tb_single_ram_ext_module;

  localparam int N = 3;
  localparam int DEP  [N] = '{128, 128, 100};
  localparam int LAT  [N] = '{1, 2, 1};
  localparam int MODE [N] = '{0, 1, 2};

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [3:0]  wea;
  logic [31:0] wdata;
  logic [6:0]  addr;
  logic [31:0] rdata  [N];
  logic        rvalid [N];
  logic        ready  [N];

  always #5 clk = ~clk;

  single_ram_ext_module #(
    .P_READ_LATENCY(1), .P_RDW_MODE(0)
  ) u0 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_wea(wea),
    .i_wdata(wdata), .i_addr(addr), .o_rdata(rdata[0]),
    .o_rvalid(rvalid[0]), .o_ready(ready[0])
  );

  single_ram_ext_module #(
    .P_READ_LATENCY(2), .P_RDW_MODE(1)
  ) u1 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_wea(wea),
    .i_wdata(wdata), .i_addr(addr), .o_rdata(rdata[1]),
    .o_rvalid(rvalid[1]), .o_ready(ready[1])
  );

  single_ram_ext_module #(
    .P_ADDR_DEPTH(100), .P_READ_LATENCY(1), .P_RDW_MODE(2)
  ) u2 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_wea(wea),
    .i_wdata(wdata), .i_addr(addr), .o_rdata(rdata[2]),
    .o_rvalid(rvalid[2]), .o_ready(ready[2])
  );

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] mm   [N][128];
  int          run  [N];
  logic        rv   [N][4];
  logic [31:0] rdq  [N][4];
  logic [31:0] last [N];

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic push(int d, int n, logic [31:0] v);
    int due;
    due = (n + LAT[d] - 1) % 4;
    rv[d][due]  = 1'b1;
    rdq[d][due] = v;
  endtask

  // Apply the rules for the upcoming edge to every model
  task automatic model_edge();
    int n;
    n = cyc + 1;
    for (int d = 0; d < N; d++) begin
      logic [31:0] old, mrg;
      bit          inr;
      if (!rst) begin
        run[d]  = 0;
        last[d] = 32'h0;
        for (int s = 0; s < 4; s++) rv[d][s] = 1'b0;
      end else begin
        if (run[d] >= DEP[d] && ena) begin
          inr = (int'(addr) < DEP[d]);
          old = inr ? mm[d][addr] : 32'h0;
          mrg = old;
          for (int k = 0; k < 4; k++)
            if (wea[k]) mrg[k*8 +: 8] = wdata[k*8 +: 8];
          if (wea == 4'h0) begin
            push(d, n, old);
          end else begin
            if (inr) mm[d][addr] = mrg;
            if (MODE[d] == 0) push(d, n, old);
            else if (MODE[d] == 1) push(d, n, inr ? mrg : 32'h0);
          end
        end
        if (run[d] < DEP[d]) begin
          run[d]++;
          if (run[d] == DEP[d])
            for (int a = 0; a < 128; a++) mm[d][a] = 32'h0;
        end
      end
    end
  endtask

  task automatic compare();
    for (int d = 0; d < N; d++) begin
      logic ev;
      ev = rv[d][cyc % 4];
      rv[d][cyc % 4] = 1'b0;
      if (ev) last[d] = rdq[d][cyc % 4];
      check($sformatf("ready%0d", d), {31'b0, ready[d]},
            {31'b0, run[d] >= DEP[d]});
      check($sformatf("rvalid%0d", d), {31'b0, rvalid[d]},
            {31'b0, ev});
      check($sformatf("rdata%0d", d), rdata[d], last[d]);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask

  task automatic req(logic e, logic [3:0] w, logic [31:0] dat,
                     logic [6:0] a);
    ena   = e;
    wea   = w;
    wdata = dat;
    addr  = a;
    step();
  endtask

  task automatic rand_req();
    req(1'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
        $urandom, 7'($urandom_range(0, 127)));
  endtask

  initial begin
    rst = 1'b0; ena = 1'b0; wea = 4'h0;
    wdata = 32'h0; addr = 7'h0;
    for (int d = 0; d < N; d++)
      for (int s = 0; s < 4; s++) rv[d][s] = 1'b0;

    // reset held, with traffic present
    for (int i = 0; i < 3; i++) rand_req();
    rst = 1'b1;

    // clear sweep with requests that must be ignored
    for (int i = 0; i < 130; i++) rand_req();
    for (int i = 0; i < 128; i++) req(1, 4'h0, 32'h0, 7'(i));
    req(0, 4'h0, 32'h0, 7'd0);
    req(0, 4'h0, 32'h0, 7'd0);

    // byte-lane merge
    req(1, 4'hF, 32'h11223344, 7'd5);
    req(1, 4'h5, 32'hAABBCCDD, 7'd5);
    req(1, 4'h0, 32'h0, 7'd5);
    check("merge_d0", rdata[0], 32'h11BB33DD);
    req(0, 4'h0, 32'h0, 7'd0);
    req(0, 4'h0, 32'h0, 7'd0);

    // back-to-back writes then reads
    for (int i = 0; i < 10; i++) req(1, 4'hF, 32'(i + 1), 7'(i));
    for (int i = 0; i < 10; i++) req(1, 4'h0, 32'h0, 7'(i));
    req(0, 4'h0, 32'h0, 7'd0);
    req(0, 4'h0, 32'h0, 7'd0);

    // read-during-write
    req(1, 4'hF, 32'h5, 7'd7);
    req(1, 4'hF, 32'h9, 7'd7);
    check("rdw_d0", rdata[0], 32'h5);
    req(0, 4'h0, 32'h0, 7'd0);
    check("rdw_d1", rdata[1], 32'h9);
    req(0, 4'h0, 32'h0, 7'd0);

    // out-of-range address on the depth-100 variant
    req(1, 4'hF, 32'hFF, 7'd120);
    req(1, 4'h0, 32'h0, 7'd120);
    check("oor_d2", rdata[2], 32'h0);
    req(1, 4'h0, 32'h0, 7'd99);
    req(0, 4'h0, 32'h0, 7'd0);
    req(0, 4'h0, 32'h0, 7'd0);

    // random traffic
    for (int i = 0; i < 400; i++) rand_req();
    req(0, 4'h0, 32'h0, 7'd0);
    req(0, 4'h0, 32'h0, 7'd0);

    // reset with a read in flight, then re-clear
    req(1, 4'hF, 32'hDEADBEEF, 7'd3);
    req(1, 4'h0, 32'h0, 7'd3);
    rst = 1'b0;
    req(0, 4'h0, 32'h0, 7'd0);
    req(0, 4'h0, 32'h0, 7'd0);
    rst = 1'b1;
    for (int i = 0; i < 130; i++) rand_req();
    req(0, 4'h0, 32'h0, 7'd0);
    req(1, 4'h0, 32'h0, 7'd3);
    req(0, 4'h0, 32'h0, 7'd0);
    req(0, 4'h0, 32'h0, 7'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
